core_inst_sequencer: RTL and testbench

// - Generates the 29-bit per-cycle instruction word for one attention core: Q/K SRAM fill, K preload into the MAC array, Q execution, OFIFO drain to psum memory, SFP normalisation into norm memory.
// - Sits between the host/testbench and the core inst input. One started job = one Q-by-K tile. Q/K double-buffer banks ping-pong between jobs.

---
 rtl/core_inst_pkg.sv | 67 ++++++
 rtl/core_inst_pack.sv | 49 ++++
 rtl/core_inst_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_inst_pkg.sv
// rtl/core_inst_pkg.sv - instruction field map and shared types for the attention core sequencer
// Purpose: bit positions of the 29-bit core instruction word, the sequencer state
//          encoding and the field bundle passed from the sequencer FSM to the packer.
// Ports:   none
package core_inst_pkg;

  localparam int INST_W = 29;
  localparam int ADDR_W = 4;

  localparam int PMEM_WR       = 0;
  localparam int PMEM_RD       = 1;
  localparam int KMEM_EVEN_WR  = 2;
  localparam int KMEM_ODD_WR   = 3;
  localparam int KMEM_EVEN_RD  = 4;
  localparam int KMEM_ODD_RD   = 5;
  localparam int QMEM_EVEN_WR  = 6;
  localparam int QMEM_ODD_WR   = 7;
  localparam int QMEM_EVEN_RD  = 8;
  localparam int QMEM_ODD_RD   = 9;
  localparam int PMEM_ADD_LSB  = 10;
  localparam int PMEM_ADD_MSB  = 13;
  localparam int QKMEM_ADD_LSB = 14;
  localparam int QKMEM_ADD_MSB = 17;
  localparam int OFIFO_RD      = 18;
  localparam int MAC_LOADK     = 19;
  localparam int MAC_EXE       = 20;
  localparam int NORM_WR       = 21;
  localparam int NORM_RD       = 22;
  localparam int NORM_ADD_LSB  = 23;
  localparam int NORM_ADD_MSB  = 26;
  localparam int SFP_INST_LSB  = 27;
  localparam int SFP_INST_MSB  = 28;

  // Two-step SFP normalisation opcodes issued back to back per row.
  localparam logic [1:0] SFP_STEP1 = 2'b01;
  localparam logic [1:0] SFP_STEP2 = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_Q = 3'd1,
    S_LOAD_K = 3'd2,
    S_KPRE   = 3'd3,
    S_EXEC   = 3'd4,
    S_DRAIN  = 3'd5,
    S_NORM   = 3'd6
  } seq_state_t;

  // Bank-agnostic view of one instruction; the packer steers q/k bits to even/odd.
  typedef struct packed {
    logic              q_wr;
    logic              q_rd;
    logic              k_wr;
    logic              k_rd;
    logic              pmem_wr;
    logic              pmem_rd;
    logic              ofifo_rd;
    logic              mac_loadk;
    logic              mac_exe;
    logic              norm_wr;
    logic              norm_rd;
    logic [ADDR_W-1:0] qk_add;
    logic [ADDR_W-1:0] pmem_add;
    logic [ADDR_W-1:0] norm_add;
    logic [1:0]        sfp_inst;
  } inst_fields_t;

endpackage

// File: rtl/core_inst_pack.sv
// rtl/core_inst_pack.sv - registered assembly of instruction fields into the core word
// Purpose: maps the bank-agnostic field bundle onto the 29-bit word, steering
//          Q/K memory strobes to the even or odd bank, and registers the result.
// Ports:   clk, reset (async, active-high), fields (from FSM), bank (job bank),
//          inst (registered instruction word).
module core_inst_pack
  import core_inst_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  inst_fields_t      fields,
  input  logic              bank,
  output logic [INST_W-1:0] inst
);

  logic [INST_W-1:0] inst_next;

  always_comb begin
    inst_next = '0;
    inst_next[PMEM_WR]      = fields.pmem_wr;
    inst_next[PMEM_RD]      = fields.pmem_rd;
    inst_next[KMEM_EVEN_WR] = fields.k_wr & ~bank;
    inst_next[KMEM_ODD_WR]  = fields.k_wr &  bank;
    inst_next[KMEM_EVEN_RD] = fields.k_rd & ~bank;
    inst_next[KMEM_ODD_RD]  = fields.k_rd &  bank;
    inst_next[QMEM_EVEN_WR] = fields.q_wr & ~bank;
    inst_next[QMEM_ODD_WR]  = fields.q_wr &  bank;
    inst_next[QMEM_EVEN_RD] = fields.q_rd & ~bank;
    inst_next[QMEM_ODD_RD]  = fields.q_rd &  bank;
    inst_next[PMEM_ADD_MSB:PMEM_ADD_LSB]   = fields.pmem_add;
    inst_next[QKMEM_ADD_MSB:QKMEM_ADD_LSB] = fields.qk_add;
    inst_next[OFIFO_RD]     = fields.ofifo_rd;
    inst_next[MAC_LOADK]    = fields.mac_loadk;
    inst_next[MAC_EXE]      = fields.mac_exe;
    inst_next[NORM_WR]      = fields.norm_wr;
    inst_next[NORM_RD]      = fields.norm_rd;
    inst_next[NORM_ADD_MSB:NORM_ADD_LSB]   = fields.norm_add;
    inst_next[SFP_INST_MSB:SFP_INST_LSB]   = fields.sfp_inst;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst <= '0;
    end else begin
      inst <= inst_next;
    end
  end

endmodule

// File: rtl/core_inst_sequencer.sv
// rtl/core_inst_sequencer.sv - per-cycle instruction sequencer for one attention core
// Purpose: runs one Q-by-K tile per accepted start: Q/K fill, K preload, Q execute,
//          OFIFO drain to psum memory, SFP normalisation; ping-pongs Q/K banks per job.
// Ports:   clk, reset (async, active-high), start, cfg_rows_m1 (Q rows - 1),
//          data_valid / data_ready (mem_in handshake), ofifo_valid,
//          inst (core word), busy, done (1-cycle), bank (0 even, 1 odd).
module core_inst_sequencer #(
  parameter int COL    = 8,
  parameter int ROW_W  = 4,
  parameter int INST_W = core_inst_pkg::INST_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ROW_W-1:0]  cfg_rows_m1,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done,
  output logic              bank
);
  import core_inst_pkg::*;

  // One spare bit so a count of 16 (R=16 or COL=16) is representable.
  localparam int CW = ROW_W + 1;

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n, rows, rows_n, cnt_inc;
  logic [1:0]    phase, phase_n;
  logic          bank_n, ready_n, busy_n, done_n;
  logic          beat;
  inst_fields_t  fields;

  assign cnt_inc = cnt + CW'(1);
  assign beat    = data_valid & data_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rows       <= '0;
      phase      <= '0;
      bank       <= 1'b0;
      data_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      rows       <= rows_n;
      phase      <= phase_n;
      bank       <= bank_n;
      data_ready <= ready_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Computes the instruction for the next cycle; the packer registers it.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rows_n  = rows;
    phase_n = phase;
    bank_n  = bank;
    ready_n = data_ready;
    busy_n  = busy;
    done_n  = 1'b0;
    fields  = '0;

    case (state)
      S_IDLE: begin
        // done is still high on the cycle we return here; a start then is dropped.
        if (start && !done) begin
          rows_n  = CW'(cfg_rows_m1) + CW'(1);
          cnt_n   = '0;
          busy_n  = 1'b1;
          ready_n = 1'b1;
          state_n = S_LOAD_Q;
        end
      end

      S_LOAD_Q: begin
        if (beat) begin
          fields.q_wr   = 1'b1;
          fields.qk_add = ADDR_W'(cnt);
          if (cnt_inc == rows) begin
            cnt_n   = '0;
            state_n = S_LOAD_K;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      S_LOAD_K: begin
        if (beat) begin
          fields.k_wr   = 1'b1;
          fields.qk_add = ADDR_W'(cnt);
          if (cnt_inc == CW'(COL)) begin
            cnt_n   = '0;
            ready_n = 1'b0;
            state_n = S_KPRE;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      // Read K row i, load it into the array one cycle later (SRAM latency).
      S_KPRE: begin
        if (cnt < CW'(COL)) begin
          fields.k_rd   = 1'b1;
          fields.qk_add = ADDR_W'(cnt);
        end
        fields.mac_loadk = (cnt != '0);
        if (cnt == CW'(COL)) begin
          cnt_n   = '0;
          state_n = S_EXEC;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      S_EXEC: begin
        if (cnt < rows) begin
          fields.q_rd   = 1'b1;
          fields.qk_add = ADDR_W'(cnt);
        end
        fields.mac_exe = (cnt != '0);
        if (cnt == rows) begin
          cnt_n   = '0;
          phase_n = '0;
          state_n = S_DRAIN;
        end else begin
          cnt_n = cnt_inc;
        end
      end

      // phase 0: wait for a full OFIFO row and pop it; phase 1: write it to psum.
      S_DRAIN: begin
        if (phase == 2'd0) begin
          if (ofifo_valid) begin
            fields.ofifo_rd = 1'b1;
            phase_n         = 2'd1;
          end
        end else begin
          fields.pmem_wr  = 1'b1;
          fields.pmem_add = ADDR_W'(cnt);
          phase_n         = 2'd0;
          if (cnt_inc == rows) begin
            cnt_n   = '0;
            state_n = S_NORM;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      S_NORM: begin
        phase_n = phase + 2'd1;
        case (phase)
          2'd0: begin
            fields.pmem_rd  = 1'b1;
            fields.pmem_add = ADDR_W'(cnt);
          end
          2'd1: fields.sfp_inst = SFP_STEP1;
          2'd2: fields.sfp_inst = SFP_STEP2;
          default: begin
            fields.norm_wr  = 1'b1;
            fields.norm_add = ADDR_W'(cnt);
            if (cnt_inc == rows) begin
              cnt_n   = '0;
              done_n  = 1'b1;
              busy_n  = 1'b0;
              bank_n  = ~bank;
              state_n = S_IDLE;
            end else begin
              cnt_n = cnt_inc;
            end
          end
        endcase
      end

      default: state_n = S_IDLE;
    endcase
  end

  core_inst_pack u_pack (
    .clk    (clk),
    .reset  (reset),
    .fields (fields),
    .bank   (bank),
    .inst   (inst)
  );

endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb/tb_core_inst_sequencer.sv - self-checking bench for core_inst_sequencer
module tb_core_inst_sequencer;

  localparam int COL  = 8;
  localparam int MAXC = 512;

  localparam int P_PMEM_WR  = 0;
  localparam int P_PMEM_RD  = 1;
  localparam int P_KE_WR    = 2;
  localparam int P_KO_WR    = 3;
  localparam int P_KE_RD    = 4;
  localparam int P_KO_RD    = 5;
  localparam int P_QE_WR    = 6;
  localparam int P_QO_WR    = 7;
  localparam int P_QE_RD    = 8;
  localparam int P_QO_RD    = 9;
  localparam int P_PADD     = 10;
  localparam int P_QKADD    = 14;
  localparam int P_OFIFO_RD = 18;
  localparam int P_LOADK    = 19;
  localparam int P_EXE      = 20;
  localparam int P_NORM_WR  = 21;
  localparam int P_NADD     = 23;
  localparam int P_SFP      = 27;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_rows_m1 = 4'd0;
  logic        data_valid = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic        data_ready;
  logic [28:0] inst;
  logic        busy;
  logic        done;
  logic        bank;

  int total = 0;
  int passed = 0;

  bit          dv[MAXC];
  bit          ov[MAXC];
  logic [28:0] e_inst[MAXC];
  bit          e_rdy[MAXC];
  bit          exp_bank = 1'b0;

  core_inst_sequencer #(.COL(COL), .ROW_W(4), .INST_W(29)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_rows_m1 (cfg_rows_m1),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done),
    .bank        (bank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [28:0] bv(input int pos);
    bv = 29'd1 << pos;
  endfunction

  function automatic logic [28:0] fld(input int lsb, input int val);
    fld = 29'(val & 15) << lsb;
  endfunction

  // Input patterns indexed by cycle relative to the start cycle (cycle 0).
  task automatic fill(input int mode);
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        1: begin
          dv[c] = (c > 7) || (c % 2 == 1);
          ov[c] = !(c >= 32 && c <= 36);
        end
        2: begin
          dv[c] = (c >= 200) || ($urandom_range(0, 3) != 0);
          ov[c] = (c >= 200) || ($urandom_range(0, 3) != 0);
        end
        default: begin
          dv[c] = 1'b1;
          ov[c] = 1'b1;
        end
      endcase
    end
  endtask

  // Expected trace of one job: instruction word and data_ready per cycle, plus
  // the cycle on which done (and the last norm write) appears.
  task automatic build_model(input int rm1, input bit b, output int dcyc);
    int r, t, n;
    r = rm1 + 1;
    for (int i = 0; i < MAXC; i++) begin
      e_inst[i] = '0;
      e_rdy[i]  = 1'b0;
    end
    t = 1;
    n = 0;
    while (n < r + COL) begin
      e_rdy[t] = 1'b1;
      if (dv[t]) begin
        if (n < r) e_inst[t+1] = bv(b ? P_QO_WR : P_QE_WR) | fld(P_QKADD, n);
        else       e_inst[t+1] = bv(b ? P_KO_WR : P_KE_WR) | fld(P_QKADD, n - r);
        n++;
      end
      t++;
    end
    for (int i = 0; i <= COL; i++) begin
      if (i < COL) e_inst[t+i+1] = e_inst[t+i+1] | bv(b ? P_KO_RD : P_KE_RD) | fld(P_QKADD, i);
      if (i > 0)   e_inst[t+i+1] = e_inst[t+i+1] | bv(P_LOADK);
    end
    t += COL + 1;
    for (int i = 0; i <= r; i++) begin
      if (i < r) e_inst[t+i+1] = e_inst[t+i+1] | bv(b ? P_QO_RD : P_QE_RD) | fld(P_QKADD, i);
      if (i > 0) e_inst[t+i+1] = e_inst[t+i+1] | bv(P_EXE);
    end
    t += r + 1;
    for (int j = 0; j < r; j++) begin
      while (!ov[t]) t++;
      e_inst[t+1] = bv(P_OFIFO_RD);
      e_inst[t+2] = bv(P_PMEM_WR) | fld(P_PADD, j);
      t += 2;
    end
    for (int j = 0; j < r; j++) begin
      e_inst[t+1] = bv(P_PMEM_RD) | fld(P_PADD, j);
      e_inst[t+2] = fld(P_SFP, 1);
      e_inst[t+3] = fld(P_SFP, 2);
      e_inst[t+4] = bv(P_NORM_WR) | fld(P_NADD, j);
      t += 4;
    end
    dcyc = t;
  endtask

  task automatic run_job(input int job, input int rm1, input bit noise, input int abort_at,
                         output int obs_done);
    int d, last, n_norm, n_done;
    bit b, eb;
    b = exp_bank;
    build_model(rm1, b, d);
    last = (abort_at >= 0) ? abort_at : d + 2;
    obs_done = -1;
    n_norm = 0;
    n_done = 0;
    for (int c = 0; c <= last; c++) begin
      start       = (c == 0) || (noise && (c == 24 || c == d));
      cfg_rows_m1 = (c == 0) ? 4'(rm1) : 4'($urandom);
      data_valid  = dv[c];
      ofifo_valid = ov[c];
      if (c == abort_at) break;
      @(negedge clk);
      eb = (c >= d) ? !b : b;
      chk($sformatf("j%0d c%0d inst", job, c), 32'(inst), 32'(e_inst[c]));
      chk($sformatf("j%0d c%0d data_ready", job, c), 32'(data_ready), 32'(e_rdy[c]));
      chk($sformatf("j%0d c%0d busy", job, c), 32'(busy), 32'(c >= 1 && c < d));
      chk($sformatf("j%0d c%0d done", job, c), 32'(done), 32'(c == d));
      chk($sformatf("j%0d c%0d bank", job, c), 32'(bank), 32'(eb));
      if (done === 1'b1) begin
        n_done++;
        if (obs_done < 0) obs_done = c;
      end
      if (inst[P_NORM_WR] === 1'b1) n_norm++;
      @(posedge clk);
      #1;
    end
    if (abort_at < 0) begin
      chk($sformatf("j%0d norm_wr count", job), 32'(n_norm), 32'(rm1 + 1));
      chk($sformatf("j%0d done count", job), 32'(n_done), 32'd1);
      exp_bank = !b;
    end
    start       = 1'b0;
    data_valid  = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    int d_obs;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("in_reset inst", 32'(inst), 32'd0);
    chk("in_reset busy", 32'(busy), 32'd0);
    chk("in_reset data_ready", 32'(data_ready), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d inst", i), 32'(inst), 32'd0);
      chk($sformatf("idle%0d busy", i), 32'(busy), 32'd0);
      chk($sformatf("idle%0d done", i), 32'(done), 32'd0);
      chk($sformatf("idle%0d bank", i), 32'(bank), 32'd0);
      @(posedge clk);
      #1;
    end

    // R=4, no stalls: 1 + (4+8) + 9 + 5 + 8 + 16 = cycle 51 after the start cycle.
    fill(0);
    run_job(1, 3, 1'b0, -1, d_obs);
    chk("j1 latency", 32'(d_obs), 32'd51);

    fill(0);
    run_job(2, 3, 1'b0, -1, d_obs);
    chk("j2 latency", 32'(d_obs), 32'd51);

    // 3 load stalls plus 5 drain stalls.
    fill(1);
    run_job(3, 3, 1'b0, -1, d_obs);
    chk("j3 latency", 32'(d_obs), 32'd59);

    // Extra start pulses in EXEC and on the done cycle.
    fill(0);
    run_job(4, 3, 1'b1, -1, d_obs);
    chk("j4 latency", 32'(d_obs), 32'd51);

    fill(2);
    run_job(5, 15, 1'b0, -1, d_obs);
    fill(2);
    run_job(6, 0, 1'b0, -1, d_obs);
    fill(2);
    run_job(7, int'($urandom_range(0, 15)), 1'b0, -1, d_obs);

    // Odd-bank job aborted by reset during EXEC.
    fill(0);
    run_job(8, 3, 1'b0, 24, d_obs);
    #2 reset = 1'b1;
    #1;
    chk("midreset inst", 32'(inst), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset bank", 32'(bank), 32'd0);
    chk("midreset data_ready", 32'(data_ready), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    exp_bank = 1'b0;

    fill(0);
    run_job(9, 3, 1'b0, -1, d_obs);
    chk("j9 latency", 32'(d_obs), 32'd51);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
